pipelined_nbit_adder: RTL and testbench
=======================================

// Module: pipelined_nbit_adder
// PURPOSE
//  Parametrised, pipelined N-bit add/subtract unit. The carry chain is cut into STAGES
//  equal ripple chunks, with a register on the carry between chunks.
//  Valid/ready stream in and out. Signed overflow flag provided.
//  Drop-in datapath adder wherever a wide ripple sum cannot close timing in one cycle.
// PARAMETERS
//  N       16  operand/sum width in bits; N % STAGES == 0 (elaboration $error otherwise)
//  STAGES  4   pipeline depth = number of carry chunks, 1..N; CHUNK = N/STAGES (localparam)
// PORTS
//  clk        in   1  rising-edge clock
//  rst        in   1  synchronous, active-high reset
//  in_valid   in   1  a/b/cin/sub valid this cycle
//  in_ready   out  1  unit accepts operands this cycle
//  a          in   N  operand A
//  b          in   N  operand B
//  cin        in   1  carry in (ignored when sub=1)
//  sub        in   1  0: a+b+cin ; 1: a-b (a + ~b + 1)
//  out_valid  out  1  sum/cout/ovf valid
//  out_ready  in   1  downstream accepts result
//  sum        out  N  result, modulo 2^N
//  cout       out  1  carry out of bit N-1 (for sub: 1 = no borrow)
//  ovf        out  1  signed two's-complement overflow
// BEHAVIOUR
//  - Transfer in: in_valid && in_ready. Transfer out: out_valid && out_ready.
//  - Global advance: adv = !(out_valid && !out_ready); in_ready = adv (combinational).
//  - When adv=1: all stages shift one step; stage0 loads inputs. If in_valid=0, a bubble
//    (valid=0) enters. Bubbles do not collapse.
//  - When adv=0: every register holds; in_ready=0.
//  - Stage k (0..STAGES-1):
//    - adds chunk k of a and b' (b' = sub ? ~b : b) plus the registered carry from stage k-1.
//    - Stage 0 carry-in = sub ? 1 : cin.
//    - Upper operand chunks are skewed forward with the data; lower result chunks are
//      delayed so that all N bits of one operation emerge together.
//  - Latency: exactly STAGES cycles from accepted input to out_valid, absent stalls.
//    Throughput: 1 op/cycle.
//  - STAGES=1: single ripple chunk with registered output; latency 1.
//  - cout = carry out of bit N-1.
//  - ovf = carry into bit N-1 XOR cout. Both come from the final chunk.
//  - Results are in order; no reordering, no drops.
//  - Reset:
//    - all stage valid bits = 0; out_valid = 0; sum = 0; cout = 0; ovf = 0;
//      in_ready = 1 in the cycle after reset deasserts.
//    - Reset mid-operation discards all in-flight ops, including a stalled result.
//  - in_ready and out_valid are both 1 with out_ready=1: a simultaneous in/out transfer
//    is legal and required.
//  - Operands only need to be stable in the accept cycle. They are captured; nothing is
//    sampled later.
// CONFIGURATION
//  `PIPE_ADDER_SAT_EN defined:
//    - final stage saturates signed results: if ovf=1, sum = sign(a) ? {1'b1,{N-1{0}}}
//      : {1'b0,{N-1{1}}};
//    - sign(a) is the MSB of a, carried through the skew;
//    - ovf still reports overflow; cout unchanged.
//  Not defined: sum always wraps modulo 2^N; no saturation logic is instantiated.
// STRUCTURE
//  Shared package adder_pkg:
//    - localparam helpers: clog2; the CHUNK derivation check;
//    - typedef of the per-stage pipeline record {valid, carry, a_hi, b_hi, sum_lo, sign_a}.
//  One sub-module: adder_chunk #(W)
//    - combinational W-bit ripple, built from per-bit xor/and/or full-adder cells;
//    - outputs s, co, c_msb (carry into MSB, for ovf);
//    - instantiated STAGES times by generate.
//  Top holds only pipeline registers, skew shifting, and the handshake.
// TESTING (N=16, STAGES=4 unless stated)
//  1. a=FFFF b=0001 cin=0 sub=0 at cycle t -> cycle t+4: out_valid=1, sum=0000,
//     cout=1, ovf=0.
//  2. a=0005 b=0007 sub=1 cin=1 (ignored) -> sum=FFFE, cout=0, ovf=0.
//     a=8000 b=0001 sub=1 -> sum=7FFF, cout=1, ovf=1.
//  3. a=7FFF b=0001 sub=0 -> ovf=1;
//     sum=8000 without PIPE_ADDER_SAT_EN, sum=7FFF with it.
//     a=8000 b=FFFF -> ovf=1; sum=7FFF, or 8000 when saturated.
//  4. Stream 20 random ops back-to-back with out_ready randomly low (~30%).
//     Required: in_ready==!(out_valid&&!out_ready) every cycle; all 20 results in order,
//     match reference model a+b+cin / a-b; no duplicates.
//  5. Hold out_ready=0 with 4 ops in flight, assert rst for 1 cycle.
//     Next cycle: out_valid=0, sum=0, in_ready=1. No stale result appears afterwards.
//  6. Sweep N=8,STAGES=1 / N=32,STAGES=8 / N=12,STAGES=3 with exhaustive or random
//     vectors; latency equals STAGES; a corner with cin=1 on all-ones operands
//     propagates its carry across every chunk.

Source files
------------

// File: rtl/adder_pkg.sv
// Shared helpers for the pipelined adder.
//   clog2    : ceiling log2, for sizing counters/indices derived from N or STAGES
//   chunk_ok : legality of an N/STAGES split (STAGES in 1..N, N divisible by STAGES)
// The per-stage pipeline record depends on N, so it is declared inside the
// top module where N is known; its layout is {valid, carry, a_hi, b_hi, sum_lo,
// sign_a, ovf}.
package adder_pkg;

    function automatic int clog2(input int v);
        int r;
        int x;
        r = 0;
        x = v - 1;
        while (x > 0) begin
            r++;
            x = x >>> 1;
        end
        return r;
    endfunction

    function automatic bit chunk_ok(input int n, input int s);
        return (s >= 1) && (s <= n) && ((n % s) == 0);
    endfunction

endpackage

// File: rtl/adder_chunk.sv
// Combinational W-bit ripple adder built from per-bit full-adder cells.
// Ports:
//   a, b   : W-bit operands
//   ci     : carry into bit 0
//   s      : W-bit sum
//   co     : carry out of bit W-1
//   c_msb  : carry into bit W-1 (used for signed overflow)
module adder_chunk #(
    parameter int W = 4
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         ci,
    output logic [W-1:0] s,
    output logic         co,
    output logic         c_msb
);
    logic [W:0] c;

    assign c[0] = ci;

    for (genvar i = 0; i < W; i++) begin : g_bit
        assign s[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign co    = c[W];
    assign c_msb = c[W-1];
endmodule

// File: rtl/pipelined_nbit_adder.sv
// Pipelined N-bit add/subtract. The carry chain is split into STAGES equal
// chunks; each stage adds one chunk and registers its carry, while the not yet
// used operand bits travel forward and finished sum bits travel along, so all N
// result bits leave together after STAGES cycles.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   in_valid/in_ready   : operand handshake (a, b, cin, sub)
//   sub                 : 0 -> a+b+cin, 1 -> a-b (cin ignored)
//   out_valid/out_ready : result handshake (sum, cout, ovf)
//   cout                : carry out of bit N-1 (subtract: 1 = no borrow)
//   ovf                 : signed two's-complement overflow
// Build option: define PIPE_ADDER_SAT_EN to saturate signed results on overflow.
module pipelined_nbit_adder
    import adder_pkg::*;
#(
    parameter int N      = 16,
    parameter int STAGES = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    input  logic         sub,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] sum,
    output logic         cout,
    output logic         ovf
);
    localparam int CHUNK = N / STAGES;

    if (!chunk_ok(N, STAGES)) begin : g_bad_cfg
        $error("pipelined_nbit_adder: N must be a multiple of STAGES and STAGES in 1..N");
    end

    // b_hi already carries the inverted operand for subtraction; ovf is only
    // meaningful in the last stage.
    typedef struct packed {
        logic         valid;
        logic         carry;
        logic [N-1:0] a_hi;
        logic [N-1:0] b_hi;
        logic [N-1:0] sum_lo;
        logic         sign_a;
        logic         ovf;
    } stage_t;

    stage_t st_q [STAGES];
    stage_t st_d [STAGES];
    logic   adv;

    // One global enable: the whole pipe moves unless a finished result is stalled.
    assign adv      = !(st_q[STAGES-1].valid && !out_ready);
    assign in_ready = adv;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        stage_t           src_s;
        stage_t           nxt_s;
        logic [CHUNK-1:0] s_w;
        logic             co_w;
        logic             cm_w;
        logic             unused_bits;

        if (k == 0) begin : g_first
            always_comb begin
                src_s        = '0;
                src_s.valid  = in_valid;
                src_s.carry  = sub ? 1'b1 : cin;
                src_s.a_hi   = a;
                src_s.b_hi   = sub ? ~b : b;
                src_s.sign_a = a[N-1];
            end
        end else begin : g_next
            assign src_s = st_q[k-1];
        end

        adder_chunk #(.W(CHUNK)) u_chunk (
            .a    (src_s.a_hi[k*CHUNK +: CHUNK]),
            .b    (src_s.b_hi[k*CHUNK +: CHUNK]),
            .ci   (src_s.carry),
            .s    (s_w),
            .co   (co_w),
            .c_msb(cm_w)
        );

        always_comb begin
            nxt_s                          = src_s;
            nxt_s.carry                    = co_w;
            nxt_s.sum_lo[k*CHUNK +: CHUNK] = s_w;
            nxt_s.ovf                      = cm_w ^ co_w;
`ifdef PIPE_ADDER_SAT_EN
            // Clamp to the most negative / most positive value by sign of a.
            if ((k == STAGES - 1) && nxt_s.ovf) begin
                if (src_s.sign_a) begin
                    nxt_s.sum_lo        = '0;
                    nxt_s.sum_lo[N-1]   = 1'b1;
                end else begin
                    nxt_s.sum_lo        = '1;
                    nxt_s.sum_lo[N-1]   = 1'b0;
                end
            end
`endif
        end

        assign st_d[k] = nxt_s;

        // Operand bits below the current chunk are dead in later stages.
        assign unused_bits = ^st_q[k];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < STAGES; k++) st_q[k] <= '0;
        end else if (adv) begin
            for (int k = 0; k < STAGES; k++) st_q[k] <= st_d[k];
        end
    end

    assign out_valid = st_q[STAGES-1].valid;
    assign sum       = st_q[STAGES-1].sum_lo;
    assign cout      = st_q[STAGES-1].carry;
    assign ovf       = st_q[STAGES-1].ovf;
endmodule

// File: tb/tb_pipelined_nbit_adder.sv
// Directed bench for pipelined_nbit_adder: main instance N=16/STAGES=4 plus
// N=8/1, N=32/8 and N=12/3 instances for the width/depth sweep.
module tb_pipelined_nbit_adder;
`ifdef PIPE_ADDER_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic clk;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;

    // instance 0: N=16 STAGES=4
    logic        in_valid0, in_ready0, cin0, sub0, out_valid0, out_ready0, cout0, ovf0;
    logic [15:0] a0, b0, sum0;
    // instance 1: N=8 STAGES=1
    logic        in_valid1, in_ready1, cin1, sub1, out_valid1, out_ready1, cout1, ovf1;
    logic [7:0]  a1, b1, sum1;
    // instance 2: N=32 STAGES=8
    logic        in_valid2, in_ready2, cin2, sub2, out_valid2, out_ready2, cout2, ovf2;
    logic [31:0] a2, b2, sum2;
    // instance 3: N=12 STAGES=3
    logic        in_valid3, in_ready3, cin3, sub3, out_valid3, out_ready3, cout3, ovf3;
    logic [11:0] a3, b3, sum3;

    pipelined_nbit_adder #(.N(16), .STAGES(4)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid0), .in_ready(in_ready0), .a(a0), .b(b0),
        .cin(cin0), .sub(sub0), .out_valid(out_valid0), .out_ready(out_ready0),
        .sum(sum0), .cout(cout0), .ovf(ovf0));
    pipelined_nbit_adder #(.N(8), .STAGES(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1), .a(a1), .b(b1),
        .cin(cin1), .sub(sub1), .out_valid(out_valid1), .out_ready(out_ready1),
        .sum(sum1), .cout(cout1), .ovf(ovf1));
    pipelined_nbit_adder #(.N(32), .STAGES(8)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2), .a(a2), .b(b2),
        .cin(cin2), .sub(sub2), .out_valid(out_valid2), .out_ready(out_ready2),
        .sum(sum2), .cout(cout2), .ovf(ovf2));
    pipelined_nbit_adder #(.N(12), .STAGES(3)) dut3 (
        .clk(clk), .rst(rst), .in_valid(in_valid3), .in_ready(in_ready3), .a(a3), .b(b3),
        .cin(cin3), .sub(sub3), .out_valid(out_valid3), .out_ready(out_ready3),
        .sum(sum3), .cout(cout3), .ovf(ovf3));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int w, input logic [31:0] av, input logic [31:0] bv,
                         input logic c, input logic s, input logic v);
        case (w)
            0: begin a0 = av[15:0]; b0 = bv[15:0]; cin0 = c; sub0 = s; in_valid0 = v; end
            1: begin a1 = av[7:0];  b1 = bv[7:0];  cin1 = c; sub1 = s; in_valid1 = v; end
            2: begin a2 = av;       b2 = bv;       cin2 = c; sub2 = s; in_valid2 = v; end
            default: begin a3 = av[11:0]; b3 = bv[11:0]; cin3 = c; sub3 = s; in_valid3 = v; end
        endcase
    endtask

    task automatic get(input int w, output logic vld, output logic [31:0] sm,
                       output logic co, output logic ov);
        case (w)
            0: begin vld = out_valid0; sm = 32'(sum0); co = cout0; ov = ovf0; end
            1: begin vld = out_valid1; sm = 32'(sum1); co = cout1; ov = ovf1; end
            2: begin vld = out_valid2; sm = sum2;      co = cout2; ov = ovf2; end
            default: begin vld = out_valid3; sm = 32'(sum3); co = cout3; ov = ovf3; end
        endcase
    endtask

    // One op into an idle pipe; result must appear exactly lat cycles later.
    task automatic run_op(input int w, input logic [31:0] av, input logic [31:0] bv,
                          input logic c, input logic s, input logic [31:0] es,
                          input logic ec, input logic eo, input int lat, input string tag);
        logic        vld, co, ov;
        logic [31:0] sm;
        drive(w, av, bv, c, s, 1'b1);
        tick();
        drive(w, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        for (int i = 1; i <= lat; i++) begin
            get(w, vld, sm, co, ov);
            if (i < lat) check({tag, "_early"}, 64'(vld), 64'd0);
            else         check(tag, {vld, co, ov, sm}, {1'b1, ec, eo, es});
            if (i < lat) tick();
        end
        tick();
    endtask

    function automatic logic [17:0] model(input logic [15:0] av, input logic [15:0] bv,
                                          input logic c, input logic s);
        logic [15:0] bb;
        logic [16:0] r;
        logic        o;
        logic [15:0] sm;
        bb = s ? ~bv : bv;
        r  = {1'b0, av} + {1'b0, bb} + 17'(s ? 1'b1 : c);
        o  = (av[15] == bb[15]) && (r[15] != av[15]);
        sm = r[15:0];
        if (SAT && o) sm = av[15] ? 16'h8000 : 16'h7FFF;
        return {sm, r[16], o};
    endfunction

    initial begin
        logic [17:0] exp_q[$];
        logic [15:0] ra, rb;
        logic        rc, rs;
        int          sent, got;

        rst = 1'b1;
        for (int w = 0; w < 4; w++) drive(w, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        out_ready0 = 1'b1; out_ready1 = 1'b1; out_ready2 = 1'b1; out_ready3 = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        #1;
        check("rst_out_valid", 64'(out_valid0), 64'd0);
        check("rst_sum",       64'(sum0),       64'd0);
        check("rst_cout_ovf",  64'({cout0, ovf0}), 64'd0);
        check("rst_in_ready",  64'(in_ready0),  64'd1);
        check("rst_others",    64'({out_valid1, out_valid2, out_valid3}), 64'd0);

        // Directed single ops on N=16/STAGES=4
        run_op(0, 32'hFFFF, 32'h0001, 1'b0, 1'b0, 32'h0000, 1'b1, 1'b0, 4, "add_wrap");
        run_op(0, 32'h0005, 32'h0007, 1'b1, 1'b1, 32'hFFFE, 1'b0, 1'b0, 4, "sub_neg");
        run_op(0, 32'h8000, 32'h0001, 1'b0, 1'b1, SAT ? 32'h8000 : 32'h7FFF, 1'b1, 1'b1, 4, "sub_ovf");
        run_op(0, 32'h7FFF, 32'h0001, 1'b0, 1'b0, SAT ? 32'h7FFF : 32'h8000, 1'b0, 1'b1, 4, "add_posovf");
        run_op(0, 32'h8000, 32'hFFFF, 1'b0, 1'b0, SAT ? 32'h8000 : 32'h7FFF, 1'b1, 1'b1, 4, "add_negovf");
        run_op(0, 32'hFFFF, 32'hFFFF, 1'b1, 1'b0, 32'hFFFF, 1'b1, 1'b0, 4, "cin_ones");
        run_op(0, 32'h0000, 32'h0000, 1'b1, 1'b0, 32'h0001, 1'b0, 1'b0, 4, "cin_only");

        // Random back-to-back stream with output backpressure
        sent = 0;
        got  = 0;
        ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom); rs = 1'($urandom);
        for (int cyc = 0; cyc < 300 && got < 20; cyc++) begin
            if (sent < 20) drive(0, 32'(ra), 32'(rb), rc, rs, 1'b1);
            else           drive(0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
            out_ready0 = ($urandom_range(0, 9) >= 3);
            #1;
            check("in_ready_rule", 64'(in_ready0), 64'(!(out_valid0 && !out_ready0)));
            if (out_valid0 && out_ready0) begin
                if (exp_q.size() == 0) check("stream_extra", 64'd1, 64'd0);
                else                   check("stream_res", 64'({sum0, cout0, ovf0}), 64'(exp_q.pop_front()));
                got++;
            end
            if (in_valid0 && in_ready0) begin
                exp_q.push_back(model(ra, rb, rc, rs));
                sent++;
                ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom); rs = 1'($urandom);
            end
            tick();
        end
        check("stream_count", 64'(got), 64'd20);
        check("stream_left",  64'(exp_q.size()), 64'd0);
        drive(0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        out_ready0 = 1'b1;
        for (int i = 0; i < 5; i++) tick();

        // Reset while a stalled result and a full pipe are held
        out_ready0 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(0, 32'(i + 1), 32'h0010, 1'b0, 1'b0, 1'b1);
            tick();
        end
        drive(0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        check("stall_valid", 64'({out_valid0, in_ready0}), 64'b10);
        check("stall_sum",   64'(sum0), 64'h0011);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_state", 64'({out_valid0, sum0, in_ready0}), 64'd1);
        out_ready0 = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("midrst_no_stale", 64'(out_valid0), 64'd0);
        end

        // Other widths / depths
        run_op(1, 32'hFF, 32'hFF, 1'b1, 1'b0, 32'hFF, 1'b1, 1'b0, 1, "n8_cin_ones");
        run_op(1, 32'h7F, 32'h01, 1'b0, 1'b0, SAT ? 32'h7F : 32'h80, 1'b0, 1'b1, 1, "n8_ovf");
        run_op(2, 32'hFFFFFFFF, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 8, "n32_carry_all");
        run_op(2, 32'h0, 32'h1, 1'b0, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b0, 8, "n32_sub");
        run_op(3, 32'hFFF, 32'hFFF, 1'b1, 1'b0, 32'hFFF, 1'b1, 1'b0, 3, "n12_cin_ones");
        run_op(3, 32'h000, 32'h001, 1'b0, 1'b1, 32'hFFF, 1'b0, 1'b0, 3, "n12_sub");
        run_op(3, 32'h800, 32'h001, 1'b0, 1'b1, SAT ? 32'h800 : 32'h7FF, 1'b1, 1'b1, 3, "n12_ovf");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
